genesis_pad_scanner: RTL

Parametrised multi-port reader for Sega Genesis/Mega Drive 3- and 6-button pads. It runs the 8-phase select sequence on a programmable poll rate and scans NUM_PADS ports in parallel. It auto-detects pad presence and 3-button vs 6-button type per port. Decoded button words are published atomically once per frame, with a per-pad change strobe, for the VPU input register block.

---
 rtl/genesis_pad_scanner.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/genesis_pad_scanner.sv
// Sega Genesis 3/6-button pad reader: runs the 8-phase select sequence on each
// poll tick, scans all ports in parallel and publishes decoded words per frame.
module genesis_pad_scanner #(
  parameter int NUM_PADS     = 2,
  parameter int PHASE_CYCLES = 1000,
  parameter int POLL_DIV     = 1666667
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [6*NUM_PADS-1:0]  pad_pins,
  output logic                   select,
  output logic [12*NUM_PADS-1:0] btn_out,
  output logic [NUM_PADS-1:0]    pad_present,
  output logic [NUM_PADS-1:0]    pad_six_btn,
  output logic                   frame_done,
  output logic [NUM_PADS-1:0]    btn_changed
);
  localparam int PH_W   = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam int POLL_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

  // Phase encodings chosen so select is simply the inverse of bit 0 (IDLE is even).
  typedef enum logic [3:0] {
    PH0 = 4'd0, PH1 = 4'd1, PH2 = 4'd2, PH3 = 4'd3,
    PH4 = 4'd4, PH5 = 4'd5, PH6 = 4'd6, PH7 = 4'd7,
    IDLE = 4'd8
  } state_t;

  logic [6*NUM_PADS-1:0]  pins_meta_q, pins_sync_q;
  logic [POLL_W-1:0]      poll_cnt_q;
  logic                   tick;
  state_t                 state_q;
  logic [PH_W-1:0]        phase_cnt_q;
  logic                   phase_last;
  logic                   pending_q;
  logic                   select_q;
  logic                   frame_done_q;
  logic [NUM_PADS-1:0]    btn_changed_q;
  logic [12*NUM_PADS-1:0] btn_q;
  logic [NUM_PADS-1:0]    present_q, six_q;
  logic [11:0]            shadow_btn_q [NUM_PADS];
  logic [NUM_PADS-1:0]    shadow_present_q, shadow_six_q;
  logic [5:0]             pin_s [NUM_PADS];
  logic [11:0]            pub_word [NUM_PADS];

  always_ff @(posedge clk) begin
    pins_meta_q <= pad_pins;
    pins_sync_q <= pins_meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      poll_cnt_q <= '0;
    end else if (tick) begin
      poll_cnt_q <= '0;
    end else begin
      poll_cnt_q <= poll_cnt_q + POLL_W'(1);
    end
  end

  assign tick       = (poll_cnt_q == POLL_W'(POLL_DIV - 1));
  assign phase_last = (phase_cnt_q == PH_W'(PHASE_CYCLES - 1));

  for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
    assign pin_s[gi]    = pins_sync_q[6*gi +: 6];
    assign pub_word[gi] = shadow_present_q[gi] ? shadow_btn_q[gi] : 12'h000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      phase_cnt_q      <= '0;
      pending_q        <= 1'b0;
      select_q         <= 1'b1;
      frame_done_q     <= 1'b0;
      btn_changed_q    <= '0;
      btn_q            <= '0;
      present_q        <= '0;
      six_q            <= '0;
      shadow_present_q <= '0;
      shadow_six_q     <= '0;
      for (int p = 0; p < NUM_PADS; p++) shadow_btn_q[p] <= '0;
    end else begin
      frame_done_q  <= 1'b0;
      btn_changed_q <= '0;
      if (state_q == IDLE) begin
        phase_cnt_q <= '0;
        // A tick or pending request is consumed here whether or not a frame starts.
        if (tick || pending_q) begin
          pending_q <= 1'b0;
          if (enable) begin
            state_q  <= PH0;
            select_q <= 1'b1;
          end
        end
      end else begin
        if (tick) pending_q <= 1'b1;
        if (!phase_last) begin
          phase_cnt_q <= phase_cnt_q + PH_W'(1);
        end else begin
          phase_cnt_q <= '0;
          for (int p = 0; p < NUM_PADS; p++) begin
            case (state_q)
              PH1: begin
                shadow_present_q[p] <= ~pin_s[p][2] & ~pin_s[p][3];
                shadow_btn_q[p][4]  <= ~pin_s[p][4];
                shadow_btn_q[p][10] <= ~pin_s[p][5];
              end
              PH2: begin
                shadow_btn_q[p][3:0] <= ~pin_s[p][3:0];
                shadow_btn_q[p][5]   <= ~pin_s[p][4];
                shadow_btn_q[p][6]   <= ~pin_s[p][5];
              end
              PH5: shadow_six_q[p] <= (pin_s[p][3:0] == 4'b0000);
              PH6: begin
                shadow_btn_q[p][7]  <= ~pin_s[p][2] & shadow_six_q[p];
                shadow_btn_q[p][8]  <= ~pin_s[p][1] & shadow_six_q[p];
                shadow_btn_q[p][9]  <= ~pin_s[p][0] & shadow_six_q[p];
                shadow_btn_q[p][11] <= ~pin_s[p][3] & shadow_six_q[p];
              end
              default: ;
            endcase
          end
          if (state_q == PH7) begin
            state_q      <= IDLE;
            select_q     <= 1'b1;
            frame_done_q <= 1'b1;
            for (int p = 0; p < NUM_PADS; p++) begin
              btn_q[12*p +: 12] <= pub_word[p];
              btn_changed_q[p]  <= (pub_word[p] != btn_q[12*p +: 12]);
              present_q[p]      <= shadow_present_q[p];
              six_q[p]          <= shadow_present_q[p] & shadow_six_q[p];
            end
          end else begin
            state_q  <= state_t'(state_q + 4'd1);
            select_q <= state_q[0];
          end
        end
      end
    end
  end

  assign select      = select_q;
  assign btn_out     = btn_q;
  assign pad_present = present_q;
  assign pad_six_btn = six_q;
  assign frame_done  = frame_done_q;
  assign btn_changed = btn_changed_q;
endmodule
